rs_decode_seq_ctrl: RTL and testbench
=====================================

RS_DECODE_SEQ_CTRL -- requirements
Module: rs_decode_seq_ctrl

Interface
REQ-001 Parameter SYM_W, default 8, symbol width in bits.
REQ-002 Parameter N_SYM, default 200, symbols per codeword block; legal range 2..255.
REQ-003 Parameter TIMEOUT, default 1024, maximum idle cycles waiting for a decoder-core output symbol.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  block offered.
REQ-007 in_ready  output  1  block accepted when in_valid and in_ready are both high.
REQ-008 in_data  input  N_SYM*SYM_W  received codeword; symbol i occupies bits [i*SYM_W +: SYM_W].
REQ-009 in_correct  input  1  mode, captured with the block: 1 = output corrected data, 0 = output error pattern.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-012 out_data  output  N_SYM*SYM_W  corrected data or error pattern, using the in_data symbol layout.
REQ-013 out_err_cnt  output  $clog2(N_SYM+1)  number of nonzero error symbols.
REQ-014 out_has_err  output  1  decoder core flagged an error during the block.
REQ-015 out_timeout  output  1  result incomplete because the core timed out.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 core_x  output  SYM_W  symbol driven to the decoder core.
REQ-018 core_enable  output  1  core_x is valid.
REQ-019 core_k  output  8  constant, equal to N_SYM.
REQ-020 core_clr  output  1  active-high clear to the decoder core.
REQ-021 core_error / core_valid / core_with_error  input  SYM_W/1/1  error symbol, error-symbol strobe, error flag from the core.

Function
REQ-022 States: IDLE, CLEAR, FEED, WAIT, COLLECT, DONE; all outputs registered except in_ready, which is high exactly in IDLE.
REQ-023 IDLE: on in_valid && in_ready, capture in_data and in_correct, clear error buffer, err_cnt and flags, move to CLEAR.
REQ-024 CLEAR: assert core_clr for exactly one cycle, then move to FEED.
REQ-025 FEED: for N_SYM consecutive cycles drive core_enable=1 and core_x = symbol i, i = 0..N_SYM-1; after the last symbol, move to WAIT with core_enable=0.
REQ-026 WAIT/COLLECT: each cycle with core_valid=1 stores core_error at collect index j, then increments j; the first strobe moves WAIT to COLLECT; gaps with core_valid=0 are legal.
REQ-027 core_valid SHALL be ignored in IDLE, CLEAR, FEED and DONE.
REQ-028 err_cnt increments on each stored nonzero core_error; out_has_err is the sticky OR of core_with_error from CLEAR exit to DONE entry.
REQ-029 Storing symbol j = N_SYM-1 moves to DONE on the next cycle.
REQ-030 Timeout: a counter resets on WAIT entry and on each stored symbol; reaching TIMEOUT in WAIT/COLLECT moves to DONE with out_timeout=1; unreceived symbols are treated as error 0.
REQ-031 out_data symbol j SHALL be data[j] XOR err[j] when in_correct=1, else err[j].
REQ-032 DONE: out_valid=1; out_data, out_err_cnt, out_has_err and out_timeout are stable until out_valid && out_ready, then move to IDLE with out_valid=0 on the next cycle.
REQ-033 in_ready and out_valid SHALL never be high in the same cycle; a back-to-back block is accepted no earlier than the cycle after the output handshake.

Reset
REQ-034 While rst=1, the next state is IDLE and out_valid, out_data, out_err_cnt, out_has_err, out_timeout, busy, core_enable, core_x and all counters are 0; core_clr=1; in_ready=1.
REQ-035 rst asserted mid-block abandons that block: no out_valid is produced and the first cycle after release is IDLE.

Verification
REQ-036 N_SYM=200, in_correct=1, core returns 200 zero error symbols -> out_data = in_data, out_err_cnt=0, out_has_err=0, out_timeout=0.
REQ-037 in_correct=0, core returns 8'h5A at j=3 and j=150 with core_with_error=1 -> out_data has only symbols 3 and 150 equal to 5A, out_err_cnt=2, out_has_err=1.
REQ-038 core_valid strobes with random gaps of at most 10 cycles, plus out_ready held low 20 cycles in DONE -> all 200 symbols captured in order, outputs stable, single handshake.
REQ-039 TIMEOUT=16, core stops after 100 symbols -> DONE 16 cycles after the last strobe, out_timeout=1, symbols 100..199 passed uncorrected.
REQ-040 rst pulsed for one cycle at FEED symbol 50 -> core_clr=1 during rst, no out_valid, in_ready=1 on the next cycle, and the next block decodes correctly.
REQ-041 in_valid held high across two blocks -> exactly N_SYM core_enable cycles per block, and in_ready/out_valid are never high together.

Source files
------------

// File: rtl/rs_decode_seq_ctrl.sv
// Sequences one codeword block through an RS decoder core and assembles its result.
// Latency: 1 clear + N_SYM feed cycles, then until N_SYM error strobes or TIMEOUT idle cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module rs_decode_seq_ctrl #(
   parameter int SYM_W   = 8,
   parameter int N_SYM   = 200,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_SYM*SYM_W-1:0]   in_data,
   input  logic                     in_correct,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_SYM*SYM_W-1:0]   out_data,
   output logic [$clog2(N_SYM+1)-1:0] out_err_cnt,
   output logic                     out_has_err,
   output logic                     out_timeout,
   output logic                     busy,
   output logic [SYM_W-1:0]         core_x,
   output logic                     core_enable,
   output logic [7:0]               core_k,
   output logic                     core_clr,
   input  logic [SYM_W-1:0]         core_error,
   input  logic                     core_valid,
   input  logic                     core_with_error
);

   localparam int DW = N_SYM * SYM_W;
   localparam int CW = $clog2(N_SYM + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int IW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_WAIT,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t          state;
   logic [DW-1:0]   data_q;
   logic            correct_q;
   logic [DW-1:0]   err_buf;
   logic [DW-1:0]   err_nxt;
   logic [IW-1:0]   feed_idx;
   logic [IW-1:0]   col_idx;
   logic [TW-1:0]   idle_cnt;
   logic            store;
   logic            last_sym;
   logic            timed_out;

   assign in_ready = (state == S_IDLE);
   assign core_k   = 8'(N_SYM);

   // Error buffer as it will look after this cycle's strobe, so DONE entry sees the last symbol.
   always_comb begin
      store     = ((state == S_WAIT) || (state == S_COLLECT)) && core_valid;
      err_nxt   = err_buf;
      if (store) begin
         err_nxt[int'(col_idx)*SYM_W +: SYM_W] = core_error;
      end
      last_sym  = store && (col_idx == IW'(N_SYM - 1));
      timed_out = !store && (idle_cnt == TW'(TIMEOUT - 1));
   end

   // Control FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_err_cnt <= '0;
         out_has_err <= 1'b0;
         out_timeout <= 1'b0;
         busy        <= 1'b0;
         core_enable <= 1'b0;
         core_x      <= '0;
         core_clr    <= 1'b1;
         feed_idx    <= '0;
         col_idx     <= '0;
         idle_cnt    <= '0;
      end else begin
         core_clr <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  data_q      <= in_data;
                  correct_q   <= in_correct;
                  err_buf     <= '0;
                  out_err_cnt <= '0;
                  out_has_err <= 1'b0;
                  out_timeout <= 1'b0;
                  busy        <= 1'b1;
                  core_clr    <= 1'b1;
                  feed_idx    <= '0;
                  col_idx     <= '0;
                  idle_cnt    <= '0;
                  state       <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               core_enable <= 1'b1;
               core_x      <= data_q[0 +: SYM_W];
               feed_idx    <= IW'(1);
               state       <= S_FEED;
            end
            S_FEED: begin
               out_has_err <= out_has_err | core_with_error;
               if (feed_idx == IW'(N_SYM)) begin
                  core_enable <= 1'b0;
                  core_x      <= '0;
                  idle_cnt    <= '0;
                  state       <= S_WAIT;
               end else begin
                  core_x   <= data_q[int'(feed_idx)*SYM_W +: SYM_W];
                  feed_idx <= feed_idx + IW'(1);
               end
            end
            S_WAIT, S_COLLECT: begin
               out_has_err <= out_has_err | core_with_error;
               err_buf     <= err_nxt;
               if (store) begin
                  col_idx  <= col_idx + IW'(1);
                  idle_cnt <= '0;
                  state    <= S_COLLECT;
                  if (core_error != '0) begin
                     out_err_cnt <= out_err_cnt + CW'(1);
                  end
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
               if (last_sym || timed_out) begin
                  state       <= S_DONE;
                  out_valid   <= 1'b1;
                  out_timeout <= timed_out;
                  out_data    <= correct_q ? (data_q ^ err_nxt) : err_nxt;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs_decode_seq_ctrl.sv
// Self-checking bench for rs_decode_seq_ctrl: emulates the decoder core with random
// strobe gaps and checks every DONE cycle against a block-level reference model.
module tb_rs_decode_seq_ctrl;

   localparam int SYM_W   = 8;
   localparam int N_SYM   = 200;
   localparam int TIMEOUT = 16;
   localparam int DW      = N_SYM * SYM_W;
   localparam int CW      = $clog2(N_SYM + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            in_correct;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [CW-1:0]   out_err_cnt;
   logic            out_has_err;
   logic            out_timeout;
   logic            busy;
   logic [SYM_W-1:0] core_x;
   logic            core_enable;
   logic [7:0]      core_k;
   logic            core_clr;
   logic [SYM_W-1:0] core_error;
   logic            core_valid;
   logic            core_with_error;

   always #5 clk = ~clk;

   rs_decode_seq_ctrl #(.SYM_W(SYM_W), .N_SYM(N_SYM), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_correct(in_correct),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err_cnt(out_err_cnt), .out_has_err(out_has_err), .out_timeout(out_timeout),
      .busy(busy), .core_x(core_x), .core_enable(core_enable), .core_k(core_k),
      .core_clr(core_clr), .core_error(core_error), .core_valid(core_valid),
      .core_with_error(core_with_error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model outputs for the block in flight
   logic [DW-1:0] exp_data;
   int            exp_cnt;
   bit            exp_has;
   bit            exp_to;
   bit            exp_armed = 1'b0;

   // core behaviour plan for the block in flight
   logic [7:0]    plan [N_SYM];
   bit            wplan [N_SYM];

   // first DONE-cycle snapshot, for literal checks by the caller
   logic [DW-1:0] got_data;
   int            got_cnt;
   bit            got_has;
   bit            got_to;

   logic [DW-1:0] blk;
   logic [DW-1:0] lit;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      int first;
      first = -1;
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         for (int i = N_SYM - 1; i >= 0; i--)
            if (act[i*SYM_W +: SYM_W] !== exp[i*SYM_W +: SYM_W]) first = i;
         $display("FAIL %s: symbol %0d got %h expected %h (t=%0t)", nm, first,
                  act[first*SYM_W +: SYM_W], exp[first*SYM_W +: SYM_W], $time);
      end
   endtask

   // Every cycle: handshake exclusivity, and any presented result must match the model.
   always @(negedge clk) begin
      chk("ready_valid_exclusive", in_ready && out_valid, 0);
      if (out_valid) begin
         chk("out_valid_expected", exp_armed, 1);
         chk_data("out_data", out_data, exp_data);
         chk("out_err_cnt", out_err_cnt, exp_cnt);
         chk("out_has_err", out_has_err, exp_has);
         chk("out_timeout", out_timeout, exp_to);
      end
   end

   task automatic rand_data();
      for (int i = 0; i < N_SYM; i++) blk[i*SYM_W +: SYM_W] = 8'($urandom);
   endtask

   task automatic rand_plan(input int err_den, input int we_den);
      for (int i = 0; i < N_SYM; i++) begin
         plan[i]  = ($urandom_range(0, err_den - 1) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         wplan[i] = ($urandom_range(0, we_den - 1) == 0);
      end
   endtask

   task automatic accept_block(input logic [DW-1:0] d, input bit corr);
      bit ok;
      ok = 1'b0;
      in_data    = d;
      in_correct = corr;
      in_valid   = 1'b1;
      for (int k = 0; k < 64; k++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("accept_in_time", ok, 1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_block(input logic [DW-1:0] d, input bit corr, input int nstr,
                            input int maxgap, input int hold, input bit keep_valid);
      logic [7:0] e;
      int nen;
      int bad;
      int gap;
      exp_cnt = 0;
      exp_has = 1'b0;
      exp_to  = (nstr < N_SYM);
      for (int i = 0; i < N_SYM; i++) begin
         e = (i < nstr) ? plan[i] : 8'h00;
         if (i < nstr && e != 8'h00) exp_cnt++;
         if (i < nstr && wplan[i]) exp_has = 1'b1;
         exp_data[i*SYM_W +: SYM_W] = corr ? (d[i*SYM_W +: SYM_W] ^ e) : e;
      end
      exp_armed = 1'b1;

      accept_block(d, corr);
      if (!keep_valid) in_valid = 1'b0;
      chk("clear_pulse", core_clr, 1);
      chk("busy_after_accept", busy, 1);
      chk("in_ready_low_busy", in_ready, 0);
      @(negedge clk);
      chk("clear_one_cycle", core_clr, 0);
      chk("feed_start", core_enable, 1);

      // feed phase: record symbols, throw junk strobes that must be ignored
      nen = 0;
      bad = 0;
      while (core_enable && nen < N_SYM + 5) begin
         if (nen < N_SYM && core_x !== d[nen*SYM_W +: SYM_W]) bad++;
         nen++;
         core_valid      = 1'($urandom_range(0, 1));
         core_error      = 8'($urandom);
         core_with_error = 1'b0;
         @(negedge clk);
      end
      core_valid = 1'b0;
      chk("feed_enable_cycles", nen, N_SYM);
      chk("feed_symbol_errors", bad, 0);

      // collect phase: core strobes with random idle gaps
      for (int j = 0; j < nstr; j++) begin
         gap = $urandom_range(0, maxgap);
         repeat (gap) @(negedge clk);
         core_valid      = 1'b1;
         core_error      = plan[j];
         core_with_error = wplan[j];
         @(negedge clk);
         core_valid      = 1'b0;
         core_with_error = 1'b0;
      end
      if (nstr == N_SYM) begin
         chk("done_after_last", out_valid, 1);
      end else begin
         for (int k = 0; k < TIMEOUT; k++) begin
            chk("no_early_timeout", out_valid, 0);
            @(negedge clk);
         end
         chk("timeout_done", out_valid, 1);
      end
      got_data = out_data;
      got_cnt  = int'(out_err_cnt);
      got_has  = out_has_err;
      got_to   = out_timeout;

      // hold the result; junk core activity must not disturb it
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         core_valid      = 1'($urandom_range(0, 1));
         core_error      = 8'($urandom);
         core_with_error = 1'b1;
         @(negedge clk);
      end
      core_valid      = 1'b0;
      core_with_error = 1'b0;
      chk("valid_held", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      exp_armed = 1'b0;
      chk("single_handshake", out_valid, 0);
      chk("idle_after_handshake", in_ready, 1);
      chk("busy_after_handshake", busy, 0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      in_valid        = 1'b0;
      in_data         = '0;
      in_correct      = 1'b0;
      out_ready       = 1'b0;
      core_error      = '0;
      core_valid      = 1'b0;
      core_with_error = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_core_clr", core_clr, 1);
      chk("rst_core_enable", core_enable, 0);
      chk("rst_core_x", core_x, 0);
      chk("rst_err_cnt", out_err_cnt, 0);
      chk("rst_has_err", out_has_err, 0);
      chk("rst_timeout", out_timeout, 0);
      chk("rst_out_data_zero", out_data == '0, 1);
      chk("core_k", core_k, N_SYM);
      rst = 1'b0;
      @(negedge clk);

      // clean block, corrected mode: data passes through untouched
      rand_data();
      for (int i = 0; i < N_SYM; i++) begin plan[i] = 8'h00; wplan[i] = 1'b0; end
      run_block(blk, 1'b1, N_SYM, 0, 0, 1'b0);
      chk_data("clean_passthru", got_data, blk);
      chk("clean_err_cnt", got_cnt, 0);
      chk("clean_has_err", got_has, 0);
      chk("clean_timeout", got_to, 0);

      // error-pattern mode with two 5A errors
      rand_data();
      for (int i = 0; i < N_SYM; i++) begin plan[i] = 8'h00; wplan[i] = 1'b0; end
      plan[3] = 8'h5A;   wplan[3] = 1'b1;
      plan[150] = 8'h5A; wplan[150] = 1'b1;
      run_block(blk, 1'b0, N_SYM, 3, 2, 1'b0);
      lit = '0;
      lit[3*SYM_W +: SYM_W]   = 8'h5A;
      lit[150*SYM_W +: SYM_W] = 8'h5A;
      chk_data("pattern_two_errors", got_data, lit);
      chk("pattern_err_cnt", got_cnt, 2);
      chk("pattern_has_err", got_has, 1);

      // random gaps up to 10 cycles, result held 20 cycles
      rand_data();
      rand_plan(8, 16);
      run_block(blk, 1'b1, N_SYM, 10, 20, 1'b0);

      // core stops after 100 symbols
      rand_data();
      rand_plan(4, 32);
      run_block(blk, 1'b1, 100, 6, 3, 1'b0);
      chk("to_flag", got_to, 1);
      chk("to_sym199_uncorrected", got_data[199*SYM_W +: SYM_W], blk[199*SYM_W +: SYM_W]);
      chk("to_sym100_uncorrected", got_data[100*SYM_W +: SYM_W], blk[100*SYM_W +: SYM_W]);

      // reset pulse at feed symbol 50 abandons the block
      rand_data();
      exp_armed = 1'b0;
      accept_block(blk, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      repeat (50) @(negedge clk);
      chk("abort_at_sym50", core_x, blk[50*SYM_W +: SYM_W]);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_core_clr", core_clr, 1);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_core_enable", core_enable, 0);
      chk("abort_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle_after", in_ready, 1);
      for (int k = 0; k < 40; k++) begin
         core_valid = 1'($urandom_range(0, 1));
         core_error = 8'($urandom);
         @(negedge clk);
      end
      core_valid = 1'b0;
      rand_data();
      rand_plan(6, 8);
      run_block(blk, 1'b1, N_SYM, 4, 1, 1'b0);

      // in_valid held across two back-to-back blocks
      rand_data();
      rand_plan(5, 8);
      run_block(blk, 1'b0, N_SYM, 2, 0, 1'b1);
      rand_data();
      rand_plan(5, 8);
      run_block(blk, 1'b1, N_SYM, 2, 0, 1'b0);

      // assorted random blocks
      for (int b = 0; b < 4; b++) begin
         rand_data();
         rand_plan($urandom_range(2, 10), $urandom_range(2, 40));
         run_block(blk, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, N_SYM - 1) : N_SYM,
                   $urandom_range(0, 10), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
